// File: rtl/piece_dropper_pkg.sv
// Shared definitions for the falling-piece controller: FSM states, board geometry
// and the edge masks used to stop pieces at the walls and the floor.
package piece_dropper_pkg;

  localparam int BOARD_BITS = 145;
  localparam int COLS       = 12;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    LOAD,
    FALL,
    LOCK,
    OVER
  } state_e;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;

  function automatic logic [BOARD_BITS-1:0] col_mask(input int c);
    logic [BOARD_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < BOARD_BITS; i++) begin
      if ((i % COLS) == c) m[i] = 1'b1;
    end
    return m;
  endfunction

  // The floor is every index at or beyond the last COLS cells, including the odd tail bit.
  localparam logic [BOARD_BITS-1:0] BOTTOM_MASK = {{COLS{1'b1}}, {(BOARD_BITS-COLS){1'b0}}};
  localparam logic [BOARD_BITS-1:0] LEFT_EDGE   = col_mask(0);
  localparam logic [BOARD_BITS-1:0] RIGHT_EDGE  = col_mask(COLS-1) | {1'b1, {(BOARD_BITS-1){1'b0}}};

endpackage

// File: rtl/piece_collide.sv
// Combinational shift-and-test: moves the piece one step in the requested direction
// and reports whether that step would leave the playfield or hit a settled cell.
module piece_collide
  import piece_dropper_pkg::*;
(
  input  logic [BOARD_BITS-1:0] piece_i,
  input  logic [BOARD_BITS-1:0] board_i,
  input  logic [1:0]            dir_i,
  output logic [BOARD_BITS-1:0] shifted_o,
  output logic                  blocked_o
);

  logic atEdge;
  logic overlap;

  always_comb begin
    shifted_o = piece_i;
    atEdge    = 1'b0;
    case (dir_i)
      DIR_DOWN: begin
        shifted_o = piece_i << COLS;
        atEdge    = |(piece_i & BOTTOM_MASK);
      end
      DIR_LEFT: begin
        shifted_o = piece_i >> 1;
        atEdge    = |(piece_i & LEFT_EDGE);
      end
      DIR_RIGHT: begin
        shifted_o = piece_i << 1;
        atEdge    = |(piece_i & RIGHT_EDGE);
      end
      default: begin
        shifted_o = piece_i;
        atEdge    = 1'b1;
      end
    endcase
  end

  assign overlap   = |(shifted_o & board_i);
  assign blocked_o = atEdge | overlap;

endmodule

// File: rtl/piece_dropper.sv
// Falling-piece controller: requests a shape, drops and slides it on request,
// merges it into the settled board when it lands, and flags game over on a blocked spawn.
module piece_dropper
  import piece_dropper_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  tick,
  input  logic                  mv_left,
  input  logic                  mv_right,
  input  logic [BOARD_BITS-1:0] newShape,
  output logic                  refresh,
  output logic [BOARD_BITS-1:0] piece,
  output logic [BOARD_BITS-1:0] board,
  output logic                  locked,
  output logic                  game_over
);

  state_e                  state_q, state_d;
  logic [BOARD_BITS-1:0]   piece_q, piece_d;
  logic [BOARD_BITS-1:0]   board_q, board_d;
  logic                    refresh_q, locked_q, gameOver_q;
  logic [1:0]              moveDir;
  logic [BOARD_BITS-1:0]   shifted;
  logic                    blocked;

  // Gravity wins over sideways moves; left wins over right.
  always_comb begin
    moveDir = DIR_RIGHT;
    if (tick)         moveDir = DIR_DOWN;
    else if (mv_left) moveDir = DIR_LEFT;
  end

  piece_collide u_collide (
    .piece_i   (piece_q),
    .board_i   (board_q),
    .dir_i     (moveDir),
    .shifted_o (shifted),
    .blocked_o (blocked)
  );

  always_comb begin
    state_d = state_q;
    piece_d = piece_q;
    board_d = board_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SPAWN;
          board_d = '0;
        end
      end
      SPAWN: state_d = LOAD;
      LOAD: begin
        piece_d = newShape;
        state_d = (|(newShape & board_q)) ? OVER : FALL;
      end
      FALL: begin
        // An empty piece can never land by itself, so a tick retires it straight away.
        if (tick) begin
          if (blocked || (piece_q == '0)) state_d = LOCK;
          else                            piece_d = shifted;
        end else if (mv_left || mv_right) begin
          if (!blocked) piece_d = shifted;
        end
      end
      LOCK: begin
        board_d = board_q | piece_q;
        piece_d = '0;
        state_d = SPAWN;
      end
      OVER: begin
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state they flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      piece_q    <= '0;
      board_q    <= '0;
      refresh_q  <= 1'b0;
      locked_q   <= 1'b0;
      gameOver_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      piece_q    <= piece_d;
      board_q    <= board_d;
      refresh_q  <= (state_d == SPAWN);
      locked_q   <= (state_d == LOCK);
      gameOver_q <= (state_d == OVER);
    end
  end

  assign refresh   = refresh_q;
  assign piece     = piece_q;
  assign board     = board_q;
  assign locked    = locked_q;
  assign game_over = gameOver_q;

endmodule

// File: tb/tb_piece_dropper.sv
// Scoreboard bench for piece_dropper: stimulus queues expected spawns, locks and
// state snapshots; a negedge monitor pops and compares them as the DUT reports events.
module tb_piece_dropper;
  import piece_dropper_pkg::*;

  typedef logic [BOARD_BITS-1:0] bits_t;

  typedef struct {
    string name;
    bits_t piece;
    bits_t board;
    logic  gameOver;
    logic  refresh;
  } probe_t;

  localparam bits_t T_SHAPE  = 145'h020070;
  localparam bits_t I_SHAPE  = 145'h0000F0;
  localparam bits_t SPIKE    = {1'b1, 144'h0} | 145'h020000;
  localparam bits_t B1       = T_SHAPE << 120;
  localparam bits_t B2       = B1 | (145'hF << 112);
  localparam bits_t B3       = B2 | SPIKE;

  logic  clk = 1'b0;
  logic  reset, start, tick, mvLeft, mvRight;
  bits_t newShape;
  logic  refresh, locked, gameOver;
  bits_t piece, board;

  piece_dropper dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tick      (tick),
    .mv_left   (mvLeft),
    .mv_right  (mvRight),
    .newShape  (newShape),
    .refresh   (refresh),
    .piece     (piece),
    .board     (board),
    .locked    (locked),
    .game_over (gameOver)
  );

  always #5 clk = ~clk;

  probe_t probeQ[$];
  bits_t  spawnQ[$];
  bits_t  lockQ[$];
  int     checks = 0;
  int     errors = 0;
  int     spawnWait = 0;
  bit     lockPending = 1'b0;
  bits_t  spawnExp, lockExp;

  task automatic checkOutput(input string name, input bits_t actual, input bits_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic l, input logic r, input logic s, input int n);
    tick = t; mvLeft = l; mvRight = r; start = s;
    repeat (n) begin @(posedge clk); #1; end
    tick = 1'b0; mvLeft = 1'b0; mvRight = 1'b0; start = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expectState(input string name, input bits_t p, input bits_t b, input logic go, input logic rf);
    probe_t e;
    e.name = name; e.piece = p; e.board = b; e.gameOver = go; e.refresh = rf;
    probeQ.push_back(e);
  endtask

  // Monitor: snapshots, spawn latency and lock results are compared away from the active edge.
  initial begin : monitor
    probe_t p;
    forever begin
      @(negedge clk);
      while (probeQ.size() > 0) begin
        p = probeQ.pop_front();
        checkOutput({p.name, ".piece"},    piece,              p.piece);
        checkOutput({p.name, ".board"},    board,              p.board);
        checkOutput({p.name, ".gameOver"}, bits_t'(gameOver),  bits_t'(p.gameOver));
        checkOutput({p.name, ".refresh"},  bits_t'(refresh),   bits_t'(p.refresh));
        checkOutput({p.name, ".locked"},   bits_t'(locked),    '0);
      end
      if (spawnWait > 0) begin
        spawnWait--;
        if (spawnWait == 1) checkOutput("refreshWidth", bits_t'(refresh), '0);
        if (spawnWait == 0) checkOutput("spawnPiece", piece, spawnExp);
      end
      if (refresh && spawnWait == 0) begin
        if (spawnQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedRefresh: got refresh=1, expected none");
        end else begin
          spawnExp  = spawnQ.pop_front();
          spawnWait = 2;
        end
      end
      if (lockPending) begin
        lockPending = 1'b0;
        checkOutput("lockWidth", bits_t'(locked), '0);
        checkOutput("lockedBoard", board, lockExp);
      end else if (locked) begin
        if (lockQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedLock: got locked=1, expected none");
        end else begin
          lockExp     = lockQ.pop_front();
          lockPending = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int leftover;
    reset = 1'b1; start = 1'b0; tick = 1'b0; mvLeft = 1'b0; mvRight = 1'b0;
    newShape = T_SHAPE;
    expectState("reset", '0, '0, 1'b0, 1'b0);
    idleCycles(2);
    reset = 1'b0;
    idleCycles(1);

    // First spawn, then gravity down to the floor.
    spawnQ.push_back(T_SHAPE);
    applyStimulus(0, 0, 0, 1, 1);
    idleCycles(2);
    applyStimulus(1, 0, 0, 0, 10);
    expectState("tenTicks", B1, '0, 1'b0, 1'b0);
    lockQ.push_back(B1);
    newShape = I_SHAPE;
    spawnQ.push_back(I_SHAPE);
    applyStimulus(1, 0, 0, 0, 1);
    idleCycles(3);

    // Sideways moves, walls and priority.
    applyStimulus(0, 1, 0, 0, 4);
    expectState("leftFour", 145'h00000F, B1, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 1);
    expectState("leftWall", 145'h00000F, B1, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 1);
    expectState("tickBeatsLeft", 145'h00F000, B1, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 0, 1);
    expectState("leftBeatsRight", 145'h00F000, B1, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 0, 1);
    expectState("rightOne", 145'h01E000, B1, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 0, 7);
    expectState("rightSeven", 145'hF00000, B1, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 0, 1);
    expectState("rightWall", 145'hF00000, B1, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 4);
    expectState("backLeft", 145'h0F0000, B1, 1'b0, 1'b0);

    // Land on settled cells rather than the floor.
    applyStimulus(1, 0, 0, 0, 8);
    expectState("onStack", 145'hF << 112, B1, 1'b0, 1'b0);
    lockQ.push_back(B2);
    newShape = SPIKE;
    spawnQ.push_back(SPIKE);
    applyStimulus(1, 0, 0, 0, 1);
    idleCycles(3);

    // Spike touches the floor, locks at once and leaves a cell under the spawn area.
    lockQ.push_back(B3);
    applyStimulus(1, 0, 0, 0, 1);
    newShape = T_SHAPE;
    spawnQ.push_back(T_SHAPE);
    idleCycles(3);
    expectState("gameOver", T_SHAPE, B3, 1'b1, 1'b0);
    applyStimulus(1, 1, 1, 0, 1);
    expectState("overIgnores", T_SHAPE, B3, 1'b1, 1'b0);

    // Restart: OVER -> IDLE, then IDLE -> SPAWN clears the board.
    applyStimulus(0, 0, 0, 1, 1);
    expectState("backToIdle", T_SHAPE, B3, 1'b0, 1'b0);
    newShape = '0;
    spawnQ.push_back('0);
    applyStimulus(0, 0, 0, 1, 1);
    expectState("boardCleared", T_SHAPE, '0, 1'b0, 1'b1);
    idleCycles(2);

    // Empty shape retires on the next tick without touching the board.
    lockQ.push_back('0);
    applyStimulus(1, 0, 0, 0, 1);
    newShape = T_SHAPE;
    spawnQ.push_back(T_SHAPE);
    idleCycles(3);
    applyStimulus(0, 0, 1, 0, 1);
    expectState("rightT", 145'h0400E0, '0, 1'b0, 1'b0);
    idleCycles(1);

    // Reset asserted between edges must clear outputs before the next posedge.
    reset = 1'b1;
    expectState("asyncReset", '0, '0, 1'b0, 1'b0);
    idleCycles(2);
    reset = 1'b0;
    idleCycles(2);

    for (int i = 0; i < 20; i++) begin
      if (probeQ.size() + spawnQ.size() + lockQ.size() == 0 && spawnWait == 0 && !lockPending) break;
      @(posedge clk);
    end
    leftover = probeQ.size() + spawnQ.size() + lockQ.size() + ((spawnWait != 0) ? 1 : 0) + (lockPending ? 1 : 0);
    checks++;
    if (leftover != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", leftover);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
